// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   PCSRC_*       : encodings of the pcsource steering input
//   fetch_state_t : request state machine encodings (IDLE / BUSY / DROP)
package if_fetch_pkg;

    localparam logic [1:0] PCSRC_SEQ = 2'b00;
    localparam logic [1:0] PCSRC_BR  = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;
    localparam logic [1:0] PCSRC_EXC = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DROP = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of {pc, inst} pairs, QDEPTH entries.
// Ports:
//   clk, clrn             clock, asynchronous active-low reset
//   push, push_pc/inst    write an entry at the tail
//   pop                   retire the head entry (caller guarantees non-empty)
//   flush                 empty the queue; wins over push and pop
//   count                 current occupancy
//   head_valid/pc/inst    head entry; pc/inst read as zero while empty
// Push and pop may occur together at any occupancy, including full.
module fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int QDEPTH = 4,
    parameter int CW     = $clog2(QDEPTH) + 1
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_inst,
    output logic [CW-1:0]   count,
    output logic            head_valid,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_inst
);

    localparam int AW = $clog2(QDEPTH);

    logic [XLEN-1:0] mem_pc   [QDEPTH];
    logic [XLEN-1:0] mem_inst [QDEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // Storage carries no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_pc[wr_ptr]   <= push_pc;
            mem_inst[wr_ptr] <= push_inst;
        end
    end

    // Pointers wrap naturally because QDEPTH is a power of two.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_pc    = head_valid ? mem_pc[rd_ptr]   : '0;
    assign head_inst  = head_valid ? mem_inst[rd_ptr] : '0;

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a decoupling prefetch queue and a
// variable-latency req/ack instruction-memory port.
// Ports:
//   clk, clrn            clock, asynchronous active-low reset
//   pcsource, bpc, jpc   PC steering; any pcsource other than sequential redirects
//   stall                ID cannot accept the head this cycle
//   imem_req/addr        fetch request, held with a stable address until imem_ack
//   imem_ack/rdata       one-cycle completion pulse with the fetched word
//   inst_valid/inst/pc   queue head presented to ID
//   pc4                  pc + 4 (wraps), zero while the queue is empty
//   perf_fetch/flush     accepted-fetch and redirect counters
// Build option: define IF_PERF_CNT_EN to implement the performance counters;
// otherwise both counter outputs are tied to zero.
module if_fetch_queue
    import if_fetch_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              QDEPTH       = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] EXC_VECTOR   = '0
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [1:0]      pcsource,
    input  logic [XLEN-1:0] bpc,
    input  logic [XLEN-1:0] jpc,
    input  logic            stall,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc4,
    output logic [31:0]     perf_fetch,
    output logic [31:0]     perf_flush
);

    localparam int CW = $clog2(QDEPTH) + 1;

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] fetch_pc, fetch_pc_next;
    logic [XLEN-1:0] req_addr, req_addr_next;
    logic [XLEN-1:0] target;
    logic            redirect;
    logic            push;
    logic            pop;
    logic            issue;
    logic            room;
    logic [CW-1:0]   count;
    logic [CW:0]     occ_next;

    assign redirect = (pcsource != PCSRC_SEQ);

    always_comb begin
        target = EXC_VECTOR;
        case (pcsource)
            PCSRC_BR:  target = bpc;
            PCSRC_JMP: target = jpc;
            default:   target = EXC_VECTOR;
        endcase
    end

    // A redirect suppresses both pop and push; the queue is flushed instead.
    assign pop  = inst_valid & ~stall & ~redirect;
    assign push = (state == BUSY) & imem_ack & ~redirect;

    // Occupancy after this cycle's push/pop plus the request about to be
    // issued. Counting the in-flight request here is what makes overflow
    // impossible: every outstanding fetch already owns a slot.
    assign occ_next = {1'b0, count} + (CW+1)'(push) - (CW+1)'(pop) + (CW+1)'(1);
    assign room     = (occ_next <= (CW+1)'(QDEPTH));

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_addr_next = req_addr;
        issue         = 1'b0;
        case (state)
            IDLE: begin
                if (!redirect && room) issue = 1'b1;
            end
            BUSY: begin
                if (redirect) begin
                    // Ack in the redirect cycle is simply discarded; otherwise
                    // the outstanding fetch must still be absorbed in DROP.
                    state_next = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    if (room) issue = 1'b1;
                    else      state_next = IDLE;
                end
            end
            DROP: begin
                if (imem_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (issue) begin
            state_next    = BUSY;
            req_addr_next = fetch_pc;
            fetch_pc_next = fetch_pc + XLEN'(4);
        end
        if (redirect) fetch_pc_next = target;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR;
            req_addr <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
        end
    end

    assign imem_req  = (state != IDLE);
    assign imem_addr = req_addr;

    fetch_queue #(
        .XLEN   (XLEN),
        .QDEPTH (QDEPTH),
        .CW     (CW)
    ) u_queue (
        .clk        (clk),
        .clrn       (clrn),
        .push       (push),
        .pop        (pop),
        .flush      (redirect),
        .push_pc    (req_addr),
        .push_inst  (imem_rdata),
        .count      (count),
        .head_valid (inst_valid),
        .head_pc    (pc),
        .head_inst  (inst)
    );

    assign pc4 = inst_valid ? (pc + XLEN'(4)) : '0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (push)     fetch_cnt <= fetch_cnt + 32'd1;
            if (redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_fetch = fetch_cnt;
    assign perf_flush = flush_cnt;
`else
    assign perf_fetch = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a behavioural memory answers requests,
// accepted fetches are queued as expected {pc, inst} pairs, and every cycle the
// DUT head is compared against the front of that queue.
module tb_if_fetch_queue;

    localparam int          XLEN   = 32;
    localparam int          QDEPTH = 4;
    localparam logic [31:0] RV     = 32'h0;
    localparam logic [31:0] EV     = 32'h180;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [1:0]  pcsource = 2'b00;
    logic [31:0] bpc = '0;
    logic [31:0] jpc = '0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] perf_fetch;
    logic [31:0] perf_flush;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN         (XLEN),
        .QDEPTH       (QDEPTH),
        .RESET_VECTOR (RV),
        .EXC_VECTOR   (EV)
    ) dut (
        .clk        (clk),
        .clrn       (clrn),
        .pcsource   (pcsource),
        .bpc        (bpc),
        .jpc        (jpc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .pc         (pc),
        .pc4        (pc4),
        .perf_fetch (perf_fetch),
        .perf_flush (perf_flush)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    logic [63:0] sb[$];
    bit          req_seen;
    int          cnt;
    int          lat;
    logic [31:0] cur_addr;
    logic [31:0] exp_addr;
    bit          stale;
    int          m_fetch;
    int          m_flush;
    int          n_req;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: evaluate current outputs with the inputs already set,
    // drive the memory response, then advance past the next rising edge.
    task automatic step();
        bit          redir;
        bit          acked;
        logic [63:0] e;
        logic [31:0] e_pc4;
        redir = (pcsource != 2'b00);
        acked = 1'b0;

        check("inst_valid", inst_valid, sb.size() != 0);
        if (inst_valid && !stall && !redir && sb.size() != 0) begin
            e     = sb.pop_front();
            e_pc4 = e[63:32] + 32'd4;
            check("head_pc", pc, e[63:32]);
            check("head_inst", inst, e[31:0]);
            check("head_pc4", pc4, e_pc4);
        end

        imem_ack = 1'b0;
        if (req_seen) begin
            check("req_hold", imem_req, 1'b1);
            check("addr_hold", imem_addr, cur_addr);
            if (cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_data(cur_addr);
                acked      = 1'b1;
                if (!stale && !redir) begin
                    sb.push_back({cur_addr, imem_rdata});
                    m_fetch++;
                end
                stale = 1'b0;
            end
        end else if (imem_req) begin
            check("req_addr", imem_addr, exp_addr);
            cur_addr = imem_addr;
            exp_addr = exp_addr + 32'd4;
            req_seen = 1'b1;
            cnt      = lat;
            n_req++;
        end

        if (redir) begin
            if (req_seen && !acked) stale = 1'b1;
            sb.delete();
            m_flush++;
            case (pcsource)
                2'b01:   exp_addr = bpc;
                2'b10:   exp_addr = jpc;
                default: exp_addr = EV;
            endcase
        end
        check("no_overflow", sb.size() <= QDEPTH, 1'b1);

        @(posedge clk);
        #1;
        if (acked) req_seen = 1'b0;
        else if (req_seen) cnt--;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        clrn       = 1'b0;
        pcsource   = 2'b00;
        stall      = 1'b0;
        bpc        = '0;
        jpc        = '0;
        imem_ack   = 1'b0;
        imem_rdata = '0;
        sb.delete();
        req_seen = 1'b0;
        stale    = 1'b0;
        cnt      = 0;
        exp_addr = RV;
        m_fetch  = 0;
        m_flush  = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_pc4", pc4, 32'h0);
        check("rst_perf_fetch", perf_fetch, 32'h0);
        check("rst_perf_flush", perf_flush, 32'h0);
        clrn = 1'b1;
    endtask

    task automatic perf_check();
`ifdef IF_PERF_CNT_EN
        check("perf_fetch", perf_fetch, 32'(m_fetch));
        check("perf_flush", perf_flush, 32'(m_flush));
`else
        check("perf_fetch", perf_fetch, 32'h0);
        check("perf_flush", perf_flush, 32'h0);
`endif
    endtask

    // Step until the next new request is seen; returns its address check.
    task automatic expect_next_req(input string tag, input logic [31:0] want);
        int n0;
        n0 = n_req;
        for (int i = 0; i < 20 && n_req == n0; i++) step();
        if (n_req == n0) check({tag, "_timeout"}, 1'b0, 1'b1);
        else check(tag, cur_addr, want);
    endtask

    initial begin
        n_req = 0;
        lat   = 1;

        // 1: streaming from reset, single-cycle memory
        do_reset();
        lat = 1;
        run(3);
        check("first_valid_cycle3", inst_valid, 1'b1);
        run(20);
        perf_check();

        // 2: stall held fills the queue, then drains in order
        do_reset();
        lat   = 1;
        stall = 1'b1;
        run(25);
        check("full_count", sb.size(), QDEPTH);
        check("full_req_low", imem_req, 1'b0);
        check("full_valid", inst_valid, 1'b1);
        stall = 1'b0;
        expect_next_req("resume_addr", 32'h10);
        run(20);
        perf_check();

        // 3: branch redirect while a slow fetch is outstanding
        do_reset();
        lat = 3;
        for (int i = 0; i < 20 && !(req_seen && cnt > 0); i++) step();
        check("busy_before_redirect", req_seen && cnt > 0, 1'b1);
        pcsource = 2'b01;
        bpc      = 32'h100;
        step();
        pcsource = 2'b00;
        check("flushed_after_br", inst_valid, 1'b0);
        expect_next_req("br_target", 32'h100);
        run(15);
        perf_check();

        // 4: exception redirect in the same cycle as the ack
        do_reset();
        lat = 1;
        run(6);
        for (int i = 0; i < 20 && !(req_seen && cnt == 0); i++) step();
        check("ack_window", req_seen && cnt == 0, 1'b1);
        pcsource = 2'b11;
        step();
        pcsource = 2'b00;
        check("flushed_after_exc", inst_valid, 1'b0);
        expect_next_req("exc_target", EV);
        run(10);
        perf_check();

        // 5: fill, then release so push and pop overlap near full
        do_reset();
        lat   = 1;
        stall = 1'b1;
        run(20);
        stall = 1'b0;
        run(30);
        perf_check();

        // 6: counters over a run with two redirects
        do_reset();
        lat = 1;
        run(22);
        pcsource = 2'b10;
        jpc      = 32'h40;
        step();
        pcsource = 2'b00;
        run(8);
        pcsource = 2'b01;
        bpc      = 32'h200;
        step();
        pcsource = 2'b00;
        run(12);
        check("two_redirects", m_flush, 2);
        perf_check();

        // 7: PC wrap across the top of the address space
        do_reset();
        lat      = 1;
        pcsource = 2'b10;
        jpc      = 32'hFFFF_FFF8;
        step();
        pcsource = 2'b00;
        expect_next_req("wrap_first", 32'hFFFF_FFF8);
        run(16);
        perf_check();

        // 8: randomised stall, latency and redirects
        do_reset();
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            lat   = $urandom_range(1, 3);
            if ($urandom_range(0, 11) == 0) begin
                pcsource = 2'($urandom_range(1, 3));
                bpc      = $urandom & 32'hFFFF_FFFC;
                jpc      = $urandom;
            end else begin
                pcsource = 2'b00;
            end
            step();
        end
        pcsource = 2'b00;
        stall    = 1'b0;
        run(20);
        perf_check();

        // reset mid-transaction abandons the request
        lat = 3;
        run(2);
        do_reset();
        lat = 1;
        run(12);
        perf_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
